// File: rtl/xkeypad_scan.sv
// rtl/xkeypad_scan.sv - 4x4 active-low keypad scanner with sweep debounce and valid/ack key report
module xkeypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 4,
  parameter int CNT_W    = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       valid_o,
  input  logic       ack_i,
  output logic       overrun_o
);

  localparam int               ST_W     = (DEB_CNT < 1) ? 1 : $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [ST_W-1:0]  DEB_MAX  = ST_W'(DEB_CNT);
  // Bit 4 set marks "no key" so a result can be compared as one value.
  localparam logic [4:0]       RES_NONE = 5'h10;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       samp0_q, samp0_d;
  logic [3:0]       samp1_q, samp1_d;
  logic [3:0]       samp2_q, samp2_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [4:0]       prev_q, prev_d;
  logic             armed_q, armed_d;
  logic             acc_q, acc_d;
  logic [3:0]       acc_key_q, acc_key_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [15:0]      sweep_rows;
  logic [4:0]       sweep_res;

  // Lowest pressed code over the sweep; column 3 is taken live on its sample cycle.
  always_comb begin
    sweep_rows = {row_i, samp2_q, samp1_q, samp0_q};
    sweep_res  = RES_NONE;
    for (int k = 15; k >= 0; k--) begin
      if (!sweep_rows[k]) begin
        sweep_res = {1'b0, 4'(k)};
      end
    end
  end

  // Next-state logic: scan sequencing, sweep debounce and report/handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    samp0_d   = samp0_q;
    samp1_d   = samp1_q;
    samp2_d   = samp2_q;
    stable_d  = stable_q;
    prev_d    = prev_q;
    armed_d   = armed_q;
    acc_d     = 1'b0;
    acc_key_d = acc_key_q;
    key_d     = key_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    col_o     = 4'hF;

    // An acceptance from the previous sweep-end is delivered here; ack in the
    // same cycle frees the register so the new code replaces the old one.
    if (acc_q) begin
      if (!valid_q || ack_i) begin
        key_d   = acc_key_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack_i) begin
      valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      cnt_d    = '0;
      idx_d    = '0;
      stable_d = '0;
      prev_d   = RES_NONE;
      armed_d  = 1'b1;
      if (en_i) begin
        state_d = SCAN;
      end
    end else begin
      col_o = ~(4'b0001 << idx_q);
      if (!en_i) begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        stable_d = '0;
        prev_d   = RES_NONE;
        armed_d  = 1'b1;
      end else if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0:    samp0_d = row_i;
          2'd1:    samp1_d = row_i;
          2'd2:    samp2_d = row_i;
          default: samp2_d = samp2_q;
        endcase
        if (idx_q == 2'd3) begin
          if (sweep_res == prev_q) begin
            if (stable_q != DEB_MAX) begin
              stable_d = stable_q + ST_W'(1);
            end
          end else begin
            stable_d = ST_W'(1);
            prev_d   = sweep_res;
          end
          if (stable_d == DEB_MAX) begin
            if (sweep_res[4]) begin
              armed_d = 1'b1;
            end else if (armed_q) begin
              armed_d   = 1'b0;
              acc_d     = 1'b1;
              acc_key_d = sweep_res[3:0];
            end
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      samp0_q   <= 4'hF;
      samp1_q   <= 4'hF;
      samp2_q   <= 4'hF;
      stable_q  <= '0;
      prev_q    <= RES_NONE;
      armed_q   <= 1'b1;
      acc_q     <= 1'b0;
      acc_key_q <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      samp0_q   <= samp0_d;
      samp1_q   <= samp1_d;
      samp2_q   <= samp2_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      armed_q   <= armed_d;
      acc_q     <= acc_d;
      acc_key_q <= acc_key_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign key_o     = key_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_xkeypad_scan.sv
// tb/tb_xkeypad_scan.sv - self-checking bench for xkeypad_scan against a sweep-level keypad model
module tb_xkeypad_scan;

  localparam int SD = 4;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  row_w;
  logic [3:0]  col_o, key_o;
  logic        valid_o, overrun_o;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_scan   = 1'b0;
  int          m_pos    = 0;
  logic [15:0] m_snap   = '0;
  int          m_prev   = 16;
  int          m_stable = 0;
  bit          m_armed  = 1'b1;
  bit          m_pend   = 1'b0;
  int          m_pend_key = 0;
  logic [3:0]  m_key    = '0;
  bit          m_valid  = 1'b0;
  bit          m_ovr    = 1'b0;
  int          mc, mres;

  xkeypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DC), .CNT_W(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .row_i    (row_w),
    .col_o    (col_o),
    .key_o    (key_o),
    .valid_o  (valid_o),
    .ack_i    (ack),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column line onto its row line.
  always_comb begin
    row_w = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col_o[c]) row_w[r] = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] exp_col();
    logic [3:0] one;
    one = 4'b0001;
    if (!m_scan) return 4'hF;
    return ~(one << (m_pos / SD));
  endfunction

  // Model: scan position by arithmetic, sweep result = lowest sampled pressed code.
  always @(posedge clk) begin
    if (rst) begin
      m_scan = 0; m_pos = 0; m_snap = '0; m_prev = 16; m_stable = 0; m_armed = 1;
      m_pend = 0; m_pend_key = 0; m_key = '0; m_valid = 0; m_ovr = 0;
    end else begin
      if (m_pend) begin
        if (!m_valid || ack) begin
          m_key = 4'(m_pend_key);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ack) begin
        m_valid = 0;
      end
      m_pend = 0;
      if (!m_scan) begin
        if (en) begin m_scan = 1; m_pos = 0; end
      end else if (!en) begin
        m_scan = 0; m_pos = 0; m_prev = 16; m_stable = 0; m_armed = 1;
      end else begin
        mc = m_pos / SD;
        if (m_pos % SD == SD - 1) begin
          for (int r = 0; r < 4; r++) m_snap[mc*4+r] = pressed[mc*4+r];
          if (mc == 3) begin
            mres = 16;
            for (int k = 15; k >= 0; k--) if (m_snap[k]) mres = k;
            if (mres == m_prev) m_stable = (m_stable + 1 > DC) ? DC : m_stable + 1;
            else begin m_stable = 1; m_prev = mres; end
            if (m_stable == DC) begin
              if (mres == 16) m_armed = 1;
              else if (m_armed) begin m_armed = 0; m_pend = 1; m_pend_key = mres; end
            end
          end
        end
        m_pos = (m_pos + 1) % (4 * SD);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("col", int'(col_o), int'(exp_col()));
      chk("key", int'(key_o), int'(m_key));
      chk("valid", int'(valid_o), int'(m_valid));
      chk("overrun", int'(overrun_o), int'(m_ovr));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  // Counts edges from the next rising edge until valid is seen, bounded.
  task automatic run_to_valid(input int limit, output int t);
    t = 0;
    @(posedge clk);
    @(negedge clk);
    while (!valid_o && t < limit) begin
      @(posedge clk);
      t++;
      @(negedge clk);
    end
    chk("valid_timeout", int'(valid_o), 1);
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    int n;
    m = '0;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) m[$urandom_range(0, 15)] = 1'b1;
    return m;
  endfunction

  int t;
  bit seen;

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_col", int'(col_o), 15);
    chk("rst_key", int'(key_o), 0);
    cycles(100);
    chk("idle_col", int'(col_o), 15);
    chk("idle_valid", int'(valid_o), 0);
    chk("idle_ovr", int'(overrun_o), 0);

    // Single press of key 6, latency from sweep start
    pressed = 16'h0040;
    en = 1'b1;
    run_to_valid(100, t);
    chk("lat_single", t, 33);
    chk("key_single", int'(key_o), 6);
    pulse_ack();
    chk("ack_clear", int'(valid_o), 0);
    cycles(48);
    chk("held_no_rpt", int'(valid_o), 0);
    pressed = '0;
    cycles(48);
    pressed = 16'h0040;
    run_to_valid(100, t);
    chk("key_repress", int'(key_o), 6);
    pulse_ack();

    // Bounce: toggle each sweep
    pressed = '0;
    cycles(48);
    seen = 0;
    for (int s = 0; s < 10; s++) begin
      pressed = (s % 2 == 0) ? 16'h0040 : 16'h0000;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (valid_o) seen = 1;
      end
    end
    chk("bounce_valid", int'(seen), 0);

    // Overrun
    pressed = '0;
    cycles(48);
    pressed = 16'h0040;
    run_to_valid(100, t);
    chk("ovr_first_key", int'(key_o), 6);
    pressed = '0;
    cycles(48);
    pressed = 16'h0200;
    cycles(48);
    chk("ovr_key_kept", int'(key_o), 6);
    chk("ovr_set", int'(overrun_o), 1);
    chk("ovr_valid", int'(valid_o), 1);
    pressed = '0;
    cycles(48);
    pressed = 16'h0200;
    t = 0;
    while (!m_pend && t < 100) begin @(negedge clk); t++; end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("coinc_key", int'(key_o), 9);
    chk("coinc_valid", int'(valid_o), 1);
    chk("coinc_ovr", int'(overrun_o), 1);
    pulse_ack();

    // Multi-key: 3 and 9 held
    pressed = '0;
    cycles(48);
    pressed = 16'h0208;
    run_to_valid(100, t);
    chk("multi_key", int'(key_o), 3);
    pulse_ack();

    // Enable drop mid-debounce of key 5
    pressed = '0;
    cycles(48);
    pressed = 16'h0020;
    cycles(20);
    en = 1'b0;
    @(negedge clk);
    chk("drop_col", int'(col_o), 15);
    cycles(40);
    chk("drop_no_rpt", int'(valid_o), 0);
    en = 1'b1;
    run_to_valid(100, t);
    chk("lat_reen", t, 33);
    chk("key_reen", int'(key_o), 5);
    pulse_ack();

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = (i == 2000);
      ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) pressed = rand_mask();
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xkeypad_scan.md
# xkeypad_scan

Matrix-keypad scanner for the calculator's peripheral cluster. It sits directly downstream of the power-on settle timer. Its `en` input takes that timer's `flag`, and no column is driven until `en` is high. It strobes a 4×4 active-low keypad one column at a time and debounces each full sweep. It delivers one key code per press to the CPU-side register through a valid/ack handshake.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven. Must be ≥ 2.
- `DEB_CNT`, default 4: consecutive identical sweeps needed to accept a press or a release. Must be ≥ 1.
- `CNT_W`, default 20: width of the internal dwell counter. Must satisfy `SCAN_DIV` ≤ 2^`CNT_W`.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `en`, in, 1: scan enable, wired to the settle-timer `flag`. Level-sensitive.
- `row`, in, 4: keypad row lines, active-low (pulled up externally).
- `col`, out, 4: column drive, active-low one-hot. `4'hF` means no column is driven.
- `key`, out, 4: accepted key code = `col_index*4 + row_index`.
- `valid`, out, 1: `key` holds an unacknowledged code.
- `ack`, in, 1: consumer acknowledge, sampled only while `valid` = 1.
- `overrun`, out, 1: sticky; set when a press is accepted while `valid` = 1.

## Operation
- **Reset values:** `col` = 4'hF, `key` = 0, `valid` = 0, `overrun` = 0. Also reset: dwell counter = 0, column index = 0, stable count = 0, previous result = none, armed = 1.
- **State IDLE:** `col` = 4'hF, counters held at 0.
  - Go to SCAN when `en` = 1.
- **State SCAN:**
  - Drive `col[idx]` = 0, all other columns 1. The dwell counter counts 0 to `SCAN_DIV`−1.
  - On the cycle where the counter = `SCAN_DIV`−1 (the sample cycle), latch `row` into a per-column sample. Then reset the counter and advance `idx` (3 wraps to 0).
  - The sample cycle of column 3 is the sweep-end.
- **Sweep result at sweep-end:**
  - The result is the lowest code whose row bit is 0 across the four samples, or "none".
  - When several keys are pressed, the lowest code wins.
- **Debounce at sweep-end:**
  - If the result equals the previous result, stable count increments, saturating at `DEB_CNT`.
  - Otherwise stable count = 1 and previous result = the new result.
- **Accept a press:** the stable count reaches `DEB_CNT`, the result is a key, and armed = 1.
  - On acceptance, armed clears and a report is issued.
- **Re-arm:** the stable count reaches `DEB_CNT` with result "none".
  - Moving directly from key A to key B without an intervening release produces no report.
- **Report:**
  - If `valid` = 0, or `ack` = 1 on the same cycle: load `key` and keep/assert `valid` = 1.
  - Otherwise keep the old `key` and set `overrun` = 1.
- **Handshake:**
  - `ack` = 1 while `valid` = 1 clears `valid` on the next edge.
  - `ack` while `valid` = 0 is ignored.
  - `key` holds its value after `valid` clears.
- **`en` falls in SCAN:** next edge goes to IDLE with `col` = 4'hF.
  - Dwell counter, `idx`, stable count and previous result are cleared, and armed is set.
  - `key`, `valid` and `overrun` are retained.
- **`overrun`:** cleared only by `rst`.

## Timing
- `col` leaves 4'hF on the edge after `en` is first seen high in IDLE.
- `col` changes every `SCAN_DIV` cycles. One sweep = 4·`SCAN_DIV` cycles.
- **Row sampling:** `row` is sampled on the last dwell cycle of each column, giving `SCAN_DIV`−1 cycles of settling.
- **`valid` latency:** `valid` rises on the edge following the sweep-end where acceptance occurs.
  - For a press stable from the start of a sweep, this is `DEB_CNT`·4·`SCAN_DIV` + 1 cycles after the sweep starts.
- **`ack`-to-clear latency:** one cycle.
- **Reset priority:** `rst` overrides `en`, `ack` and everything else on the same edge.

## Test plan
All scenarios use `SCAN_DIV` = 4 and `DEB_CNT` = 2, so one sweep = 16 cycles.

- **Reset and idle:** assert `rst` with `en` = 0, then hold 100 cycles → `col` = F, `valid` = 0, `overrun` = 0 throughout.
- **Single press:**
  - Stimulus: `en` = 1; pull `row[2]` low whenever `col[1]` = 0.
  - Response: `valid` rises 33 cycles after the first sweep start, with `key` = 6.
  - Pulse `ack` → `valid` = 0 on the next cycle. No further report while the key is held.
  - Release for 2 sweeps, then press again → second report with `key` = 6.
- **Bounce:** toggle the same press every sweep for 10 sweeps → `valid` stays 0.
- **Overrun:**
  - Press 6 → accepted. Release 2 sweeps, press 9 without `ack` → `key` stays 6, `overrun` = 1.
  - Repeat the second press with `ack` coincident with acceptance → `key` = 9, `valid` stays 1, `overrun` unchanged.
- **Multi-key:** keys 3 and 9 held together → `key` = 3.
- **Enable drop:**
  - Drop `en` mid-debounce of key 5 → `col` = F on the next edge and no report.
  - Raise `en` again with key 5 held → accepted after 2 full sweeps.
